// File: rtl/inst_seq_ctrl_if.sv
// Instruction-issue bus of the sequencer.
//
// Carries the valid/ready instruction handshake towards the datapath and the
// loop-control inputs that steer the next program counter.
//
// Handshake: the master raises inst_valid with inst_pc and holds both stable
// until a cycle where inst_valid & inst_ready (and no datapath stall) is seen
// at the clock edge; that cycle is the one transfer. The slave may drive
// inst_ready freely, it never depends on inst_valid.
//
// Signals
//   inst_valid      master -> slave  inst_pc carries an instruction to run
//   inst_ready      slave  -> master datapath accepts the current instruction
//   inst_pc         master -> slave  current program counter
//   inst_loop_mode  slave  -> master 0 linear program, 1..3 loop nest depth
//   inst_last_addr  slave  -> master final PC of a linear program
//   inst_jump       slave  -> master loop-control jump request for inst_pc
//   inst_jump_addr  slave  -> master jump target
//   inst_loop_done  slave  -> master outermost loop complete at inst_pc
interface inst_seq_ctrl_if #(
  parameter int unsigned AW = 32
) ();
  logic          inst_valid;
  logic          inst_ready;
  logic [AW-1:0] inst_pc;
  logic [1:0]    inst_loop_mode;
  logic [AW-1:0] inst_last_addr;
  logic          inst_jump;
  logic [AW-1:0] inst_jump_addr;
  logic          inst_loop_done;

  modport master (
    output inst_valid,
    output inst_pc,
    input  inst_ready,
    input  inst_loop_mode,
    input  inst_last_addr,
    input  inst_jump,
    input  inst_jump_addr,
    input  inst_loop_done
  );

  modport slave (
    input  inst_valid,
    input  inst_pc,
    output inst_ready,
    output inst_loop_mode,
    output inst_last_addr,
    output inst_jump,
    output inst_jump_addr,
    output inst_loop_done
  );
endinterface

// File: rtl/inst_seq_ctrl.sv
// Instruction sequencer.
//
// Owns the program counter, offers one instruction address at a time on the
// issue bus and, on every accepted instruction, picks the next PC: program
// end, loop-control jump, or increment (wrapping at the top of instruction
// memory). A debug mode halts issue and allows single steps.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   clr_i        synchronous soft clear (back to IDLE, PC 0, error cleared)
//   start_i      start the program at PC 0 (ignored while busy)
//   stall_i      datapath stall, blocks the transfer
//   dbg_en_i     debug mode: halt issue
//   dbg_step_i   issue exactly one instruction while halted
//   bus          issue bus (master side): valid/ready/pc plus loop-control inputs
//   busy_o       program in progress (RUN, DBG_HALT, DBG_STEP)
//   done_o       one-cycle pulse when the program completes
//   addr_err_o   sticky: a jump targeted an address outside instruction memory
//   dbg_state_o  current FSM state, for observation only
module inst_seq_ctrl #(
  parameter int unsigned InstMemAddrWidth = 32,
  parameter int unsigned InstMemDepth     = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic                   dbg_en_i,
  input  logic                   dbg_step_i,
  inst_seq_ctrl_if.master        bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   addr_err_o,
  output logic [2:0]             dbg_state_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRun     = 3'd1;
  localparam logic [2:0] StDbgHalt = 3'd2;
  localparam logic [2:0] StDbgStep = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  // Highest legal PC; anything above it is outside instruction memory.
  localparam logic [InstMemAddrWidth-1:0] LastPc =
    InstMemAddrWidth'(InstMemDepth - 1);

  logic [2:0]                  state_q, state_d;
  logic [InstMemAddrWidth-1:0] pc_q, pc_d;
  logic                        addr_err_q, addr_err_d;

  logic                        issuing;
  logic                        fire;
  logic                        end_hit;
  logic                        jump_bad;
  logic [InstMemAddrWidth-1:0] pc_inc;

  // Valid is a pure decode of the state so it never depends on stall_i or
  // ready; the PC register only moves on a transfer, which keeps inst_pc
  // stable for as long as valid is waiting.
  assign issuing = (state_q == StRun) || (state_q == StDbgStep);
  assign fire    = issuing & bus.inst_ready & ~stall_i;

  // Next-PC ingredients, only meaningful in a fire cycle.
  always_comb begin
    end_hit  = 1'b0;
    jump_bad = 1'b0;
    pc_inc   = '0;
    if (bus.inst_loop_mode == 2'd0) begin
      end_hit = (pc_q == bus.inst_last_addr);
    end else begin
      end_hit = bus.inst_loop_done;
    end
    jump_bad = bus.inst_jump && (bus.inst_jump_addr > LastPc);
    pc_inc   = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_err_d = addr_err_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pc_d       = '0;
          addr_err_d = 1'b0;
          state_d    = dbg_en_i ? StDbgHalt : StRun;
        end
      end

      StRun, StDbgStep: begin
        // End beats jump, jump beats increment. A program end or a bad
        // jump target leaves the PC on the last issued instruction.
        if (fire) begin
          if (end_hit) begin
            state_d = StDone;
          end else if (bus.inst_jump) begin
            if (jump_bad) begin
              addr_err_d = 1'b1;
              state_d    = StDone;
            end else begin
              pc_d = bus.inst_jump_addr;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
        // Completion wins over any debug transition. A step lasts until
        // its instruction is taken; a halt request in RUN takes effect
        // immediately, with the PC update of a coincident transfer kept.
        if (state_d != StDone) begin
          if (state_q == StDbgStep) begin
            if (fire) state_d = StDbgHalt;
          end else if (dbg_en_i) begin
            state_d = StDbgHalt;
          end
        end
      end

      StDbgHalt: begin
        if (!dbg_en_i) begin
          state_d = StRun;
        end else if (dbg_step_i) begin
          state_d = StDbgStep;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Soft clear overrides everything; leaving DONE is not needed for the
    // pulse to be suppressed because the state goes straight to IDLE.
    if (clr_i) begin
      state_d    = StIdle;
      pc_d       = '0;
      addr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.inst_valid = issuing;
  assign bus.inst_pc    = pc_q;
  assign busy_o         = (state_q == StRun) || (state_q == StDbgHalt) ||
                          (state_q == StDbgStep);
  assign done_o         = (state_q == StDone);
  assign addr_err_o     = addr_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
module tb_inst_seq_ctrl;

  localparam int Depth = 1024;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clr_i, start_i, stall_i, dbg_en_i, dbg_step_i;
  logic       busy_o, done_o, addr_err_o;
  logic [2:0] dbg_state_o;

  inst_seq_ctrl_if #(.AW(32)) bus ();

  inst_seq_ctrl #(.InstMemAddrWidth(32), .InstMemDepth(Depth)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .dbg_en_i    (dbg_en_i),
    .dbg_step_i  (dbg_step_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .addr_err_o  (addr_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Scoreboard and program description
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_len, exp_last;
  bit          exp_err;
  int          p_mode, p_last, p_jpc, p_jtgt, p_jtimes, p_done_pc;
  bit          p_both;
  int          jleft;
  int          cyc;
  bit          hold_v;
  logic [31:0] hold_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: the list of PCs the program must issue, in order,
  // derived from the program description alone.
  function automatic void build_expected();
    int pc = 0;
    int left = p_jtimes;
    exp_q.delete();
    exp_err = 1'b0;
    for (int n = 0; n < 4096; n++) begin
      exp_q.push_back(32'(pc));
      if (p_mode == 0 ? (pc == p_last) : (pc == p_done_pc && left == 0)) break;
      if (pc == p_jpc && left > 0) begin
        left--;
        if (p_jtgt >= Depth) begin
          exp_err = 1'b1;
          break;
        end
        pc = p_jtgt;
      end else begin
        pc = (pc + 1) % Depth;
      end
    end
    exp_len  = exp_q.size();
    exp_last = int'(exp_q[exp_q.size()-1]);
  endfunction

  task automatic set_prog(input int mode, input int last, input int jpc, input int jtgt,
                          input int jtimes, input int done_pc, input bit both);
    p_mode = mode; p_last = last; p_jpc = jpc; p_jtgt = jtgt;
    p_jtimes = jtimes; p_done_pc = done_pc; p_both = both;
  endtask

  // Driver: one clock cycle. Plays the loop-control role from the PC on the
  // bus, checks every transfer against the expected queue and checks that a
  // waiting instruction does not change.
  task automatic cycle(input bit rdy, input bit stl);
    bit dn, jmp, f;
    logic [31:0] pc;
    pc = bus.inst_pc;
    if (hold_v) begin
      chk("hold_valid", 32'(bus.inst_valid), 1);
      chk("hold_pc", pc, hold_pc);
    end
    dn  = (p_mode != 0) && (pc == 32'(p_done_pc)) && (jleft == 0);
    jmp = ((pc == 32'(p_jpc)) && (jleft > 0)) || (p_both && dn);
    bus.inst_loop_mode = 2'(p_mode);
    bus.inst_last_addr = 32'(p_last);
    bus.inst_jump      = jmp;
    bus.inst_jump_addr = 32'(p_jtgt);
    bus.inst_loop_done = dn;
    bus.inst_ready     = rdy;
    stall_i            = stl;
    f = bus.inst_valid && rdy && !stl;
    if (f) begin
      chk("fire_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("fire_pc", pc, exp_q.pop_front());
      if ((pc == 32'(p_jpc)) && (jleft > 0)) jleft--;
      hold_v = 1'b0;
    end else begin
      hold_v  = bus.inst_valid;
      hold_pc = pc;
    end
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic do_start();
    build_expected();
    jleft  = p_jtimes;
    hold_v = 1'b0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    chk("start_valid", 32'(bus.inst_valid), 1);
    chk("start_pc", bus.inst_pc, 0);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_err_clear", 32'(addr_err_o), 0);
  endtask

  // bp: 0 none, 1 random, 2 directed (ready low 3 cycles at PC 2, stall 2 at PC 3)
  task automatic drain(input int bp, input bit timed);
    int budget = 0;
    int r_cnt = 0;
    int s_cnt = 0;
    bit rdy, stl;
    while (!done_o && budget < 600) begin
      rdy = 1'b1;
      stl = 1'b0;
      if (bp == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
        stl = ($urandom_range(0, 5) == 0);
      end else if (bp == 2 && bus.inst_valid) begin
        if (bus.inst_pc == 32'd2 && r_cnt < 3) begin rdy = 1'b0; r_cnt++; end
        if (bus.inst_pc == 32'd3 && s_cnt < 2) begin stl = 1'b1; s_cnt++; end
      end
      cycle(rdy, stl);
      budget++;
    end
    chk("done_seen", 32'(done_o), 1);
    if (timed) chk("done_latency", 32'(cyc), 32'(exp_len + 1));
    chk("all_issued", 32'(exp_q.size()), 0);
    chk("addr_err", 32'(addr_err_o), 32'(exp_err));
    chk("busy_in_done", 32'(busy_o), 0);
    chk("pc_kept", bus.inst_pc, 32'(exp_last));
    hold_v = 1'b0;
    @(posedge clk_i); #1;
    chk("done_one_cycle", 32'(done_o), 0);
    chk("idle_valid", 32'(bus.inst_valid), 0);
    chk("idle_busy", 32'(busy_o), 0);
  endtask

  initial begin
    int guard;
    rst_ni = 1'b0; clr_i = 1'b0; start_i = 1'b0; stall_i = 1'b0;
    dbg_en_i = 1'b0; dbg_step_i = 1'b0;
    bus.inst_ready = 1'b0; bus.inst_loop_mode = 2'd0; bus.inst_last_addr = '0;
    bus.inst_jump = 1'b0; bus.inst_jump_addr = '0; bus.inst_loop_done = 1'b0;
    hold_v = 1'b0; hold_pc = '0; cyc = 0; jleft = 0;
    set_prog(0, 0, 9999, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset state
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_pc", bus.inst_pc, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(addr_err_o), 0);

    // Linear run 0..4, one instruction per cycle, done in cycle 6
    set_prog(0, 4, 9999, 0, 0, 0, 1'b0);
    do_start();
    drain(0, 1'b1);

    // Directed backpressure
    set_prog(0, 6, 9999, 0, 0, 0, 1'b0);
    do_start();
    drain(2, 1'b0);

    // Loop 0,1,2,3,1,2,3,1,2,3; jump also raised at the end (done wins);
    // last_addr=1 must be ignored in loop mode
    set_prog(1, 1, 3, 1, 2, 3, 1'b1);
    do_start();
    drain(0, 1'b1);

    // Debug halt and single steps
    set_prog(0, 6, 9999, 0, 0, 0, 1'b0);
    do_start();
    guard = 0;
    while (bus.inst_pc != 32'd2 && guard < 10) begin cycle(1'b1, 1'b0); guard++; end
    chk("dbg_reach_pc2", bus.inst_pc, 2);
    dbg_en_i = 1'b1;
    cycle(1'b0, 1'b0);
    hold_v = 1'b0;
    chk("dbg_halt_valid", 32'(bus.inst_valid), 0);
    chk("dbg_halt_pc", bus.inst_pc, 2);
    chk("dbg_halt_busy", 32'(busy_o), 1);
    cycle(1'b1, 1'b0);
    chk("dbg_halt_stays", 32'(bus.inst_valid), 0);
    dbg_step_i = 1'b1;
    cycle(1'b1, 1'b0);
    dbg_step_i = 1'b0;
    chk("dbg_step1_valid", 32'(bus.inst_valid), 1);
    chk("dbg_step1_pc", bus.inst_pc, 2);
    cycle(1'b1, 1'b0);
    chk("dbg_step1_after", 32'(bus.inst_valid), 0);
    chk("dbg_step1_pc_next", bus.inst_pc, 3);
    dbg_step_i = 1'b1;
    cycle(1'b1, 1'b0);
    dbg_step_i = 1'b0;
    chk("dbg_step2_valid", 32'(bus.inst_valid), 1);
    chk("dbg_step2_pc", bus.inst_pc, 3);
    cycle(1'b1, 1'b0);
    chk("dbg_step2_after", 32'(bus.inst_valid), 0);
    chk("dbg_step2_pc_next", bus.inst_pc, 4);
    dbg_en_i = 1'b0;
    cycle(1'b1, 1'b0);
    chk("dbg_resume_valid", 32'(bus.inst_valid), 1);
    chk("dbg_resume_pc", bus.inst_pc, 4);
    drain(0, 1'b0);

    // Out-of-range jump target: error is sticky until clear
    set_prog(0, 10, 2, Depth, 1, 0, 1'b0);
    do_start();
    drain(0, 1'b1);
    repeat (2) @(posedge clk_i);
    #1 chk("err_sticky", 32'(addr_err_o), 1);
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    chk("err_cleared_by_clr", 32'(addr_err_o), 0);

    // Error again, then the next start must clear it (checked in do_start)
    do_start();
    drain(0, 1'b0);

    // Clear mid-run at PC 5 while an instruction would be accepted
    set_prog(0, 20, 9999, 0, 0, 0, 1'b0);
    do_start();
    guard = 0;
    while (bus.inst_pc != 32'd5 && guard < 20) begin cycle(1'b1, 1'b0); guard++; end
    chk("clr_reach_pc5", bus.inst_pc, 5);
    clr_i = 1'b1;
    bus.inst_ready = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    chk("clr_valid", 32'(bus.inst_valid), 0);
    chk("clr_pc", bus.inst_pc, 0);
    chk("clr_busy", 32'(busy_o), 0);
    chk("clr_no_done", 32'(done_o), 0);
    @(posedge clk_i); #1;
    chk("clr_no_done_later", 32'(done_o), 0);

    // Wrap 1022,1023,0,1; start and step pulses while running are ignored
    set_prog(0, 1, 0, 1022, 1, 0, 1'b0);
    do_start();
    cycle(1'b1, 1'b0);
    start_i = 1'b1;
    dbg_step_i = 1'b1;
    cycle(1'b1, 1'b0);
    start_i = 1'b0;
    dbg_step_i = 1'b0;
    drain(0, 1'b0);

    // Random programs under random backpressure
    for (int t = 0; t < 20; t++) begin
      int mode, jpc, jtgt, last;
      mode = $urandom_range(0, 3);
      jpc  = $urandom_range(2, 8);
      jtgt = ($urandom_range(0, 5) == 0) ? Depth + $urandom_range(0, 7)
                                         : $urandom_range(0, jpc);
      last = (mode == 0) ? jpc + $urandom_range(0, 4) : $urandom_range(0, 10);
      set_prog(mode, last, jpc, jtgt, $urandom_range(0, 3), jpc, 1'($urandom_range(0, 1)));
      do_start();
      drain(1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
